// File: rtl/dpram_pkg.sv
// ---------------------------------------------------------------------------
// dpram_pkg : shared types and helpers for param_dual_port_ram. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dpram_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } dpram_state_e;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  function automatic int dpram_lanes(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dpram_clear_seq.sv
// ---------------------------------------------------------------------------
// dpram_clear_seq : post-reset clear sequencer, one word per cycle. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dpram_clear_seq
  import dpram_pkg::*;
#(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  clr_en,
  output logic                  init_busy
);

  dpram_state_e          state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  busy_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else if (state_q == CLEAR) begin
      cnt_q <= cnt_q + ADDR_WIDTH'(1);
      // Last word written this cycle: ports open on the next one.
      if (&cnt_q) begin
        state_q <= READY;
        busy_q  <= 1'b0;
      end
    end
  end

  assign clr_addr  = cnt_q;
  assign clr_en    = rst_n && (state_q == CLEAR);
  assign init_busy = busy_q;

endmodule

`default_nettype wire

// File: rtl/param_dual_port_ram.sv
// ---------------------------------------------------------------------------
// param_dual_port_ram : byte-lane true dual-port RAM with clear-on-reset.
// Macro DPRAM_OUT_REG_EN adds an output register stage per port. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module param_dual_port_ram
  import dpram_pkg::*;
#(
  parameter int                   DATA_WIDTH = 14,
  parameter int                   ADDR_WIDTH = 6,
  parameter int                   BYTE_WIDTH = 7,
  parameter int                   RDW_MODE   = RDW_OLD,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [ADDR_WIDTH-1:0]                         a_addr,
  input  logic                                          a_read_en,
  input  logic                                          a_write_en,
  input  logic [dpram_lanes(DATA_WIDTH, BYTE_WIDTH)-1:0] a_byte_en,
  input  logic [DATA_WIDTH-1:0]                         a_data_in,
  output logic [DATA_WIDTH-1:0]                         a_data_out,
  output logic                                          a_data_valid,
  input  logic [ADDR_WIDTH-1:0]                         b_addr,
  input  logic                                          b_read_en,
  input  logic                                          b_write_en,
  input  logic [dpram_lanes(DATA_WIDTH, BYTE_WIDTH)-1:0] b_byte_en,
  input  logic [DATA_WIDTH-1:0]                         b_data_in,
  output logic [DATA_WIDTH-1:0]                         b_data_out,
  output logic                                          b_data_valid,
  output logic                                          init_busy,
  output logic                                          collision
);

  localparam int LANES = dpram_lanes(DATA_WIDTH, BYTE_WIDTH);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  clr_en;
  logic                  port_en;
  logic [LANES-1:0]      a_lane_we, b_lane_we;
  logic [DATA_WIDTH-1:0] a_rd_word, b_rd_word;
  logic [DATA_WIDTH-1:0] a_dout_d, a_dout_q, b_dout_d, b_dout_q;
  logic                  a_valid_d, a_valid_q, b_valid_d, b_valid_q;
  logic                  coll_d, coll_q;

  dpram_clear_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_clear_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_addr  (clr_addr),
    .clr_en    (clr_en),
    .init_busy (init_busy)
  );

  function automatic logic [DATA_WIDTH-1:0] lane_merge(
    input logic [DATA_WIDTH-1:0] base,
    input logic [DATA_WIDTH-1:0] wdata,
    input logic [LANES-1:0]      sel
  );
    logic [DATA_WIDTH-1:0] r;
    r = base;
    for (int l = 0; l < LANES; l++) begin
      if (sel[l]) r[l*BYTE_WIDTH +: BYTE_WIDTH] = wdata[l*BYTE_WIDTH +: BYTE_WIDTH];
    end
    return r;
  endfunction

  always_comb begin
    port_en   = rst_n && !init_busy;
    a_lane_we = (port_en && a_write_en) ? a_byte_en : '0;
    b_lane_we = (port_en && b_write_en) ? b_byte_en : '0;
    a_rd_word = mem_q[a_addr];
    b_rd_word = mem_q[b_addr];
    // Write-first: overlay B then A so shared lanes resolve to port A.
    if (RDW_MODE == RDW_NEW) begin
      a_rd_word = lane_merge(lane_merge(a_rd_word, b_data_in, b_lane_we & {LANES{b_addr == a_addr}}),
                             a_data_in, a_lane_we);
      b_rd_word = lane_merge(lane_merge(b_rd_word, b_data_in, b_lane_we),
                             a_data_in, a_lane_we & {LANES{a_addr == b_addr}});
    end
    a_valid_d = port_en && a_read_en;
    b_valid_d = port_en && b_read_en;
    a_dout_d  = a_valid_d ? a_rd_word : a_dout_q;
    b_dout_d  = b_valid_d ? b_rd_word : b_dout_q;
    coll_d    = (a_addr == b_addr) && |(a_lane_we & b_lane_we);
  end

  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem_q[clr_addr] <= INIT_VALUE;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (b_lane_we[l]) mem_q[b_addr][l*BYTE_WIDTH +: BYTE_WIDTH] <= b_data_in[l*BYTE_WIDTH +: BYTE_WIDTH];
      end
      for (int l = 0; l < LANES; l++) begin
        if (a_lane_we[l]) mem_q[a_addr][l*BYTE_WIDTH +: BYTE_WIDTH] <= a_data_in[l*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_dout_q  <= '0;
      b_dout_q  <= '0;
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      coll_q    <= 1'b0;
    end else begin
      a_dout_q  <= a_dout_d;
      b_dout_q  <= b_dout_d;
      a_valid_q <= a_valid_d;
      b_valid_q <= b_valid_d;
      coll_q    <= coll_d;
    end
  end

`ifdef DPRAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] a_out_q, b_out_q;
  logic                  a_ovalid_q, b_ovalid_q, coll_out_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_out_q    <= '0;
      b_out_q    <= '0;
      a_ovalid_q <= 1'b0;
      b_ovalid_q <= 1'b0;
      coll_out_q <= 1'b0;
    end else begin
      if (a_valid_q) a_out_q <= a_dout_q;
      if (b_valid_q) b_out_q <= b_dout_q;
      a_ovalid_q <= a_valid_q;
      b_ovalid_q <= b_valid_q;
      coll_out_q <= coll_q;
    end
  end

  assign a_data_out   = a_out_q;
  assign b_data_out   = b_out_q;
  assign a_data_valid = a_ovalid_q;
  assign b_data_valid = b_ovalid_q;
  assign collision    = coll_out_q;
`else
  assign a_data_out   = a_dout_q;
  assign b_data_out   = b_dout_q;
  assign a_data_valid = a_valid_q;
  assign b_data_valid = b_valid_q;
  assign collision    = coll_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_param_dual_port_ram.sv
// ---------------------------------------------------------------------------
// tb_param_dual_port_ram : scoreboard bench, read-first and write-first DUTs
// driven in parallel against an array-level memory model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_param_dual_port_ram;
  import dpram_pkg::*;

  localparam int DW    = 14;
  localparam int AW    = 6;
  localparam int BW    = 7;
  localparam int LN    = 2;
  localparam int DEPTH = 64;
`ifdef DPRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [LN-1:0] be;
    logic [DW-1:0] d;
  } req_t;

  typedef struct {
    logic [DW-1:0] d;
    int            c;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  req_t ra, rb;
  logic [DW-1:0] ado0, bdo0, ado1, bdo1;
  logic av0, bv0, av1, bv1, busy0, busy1, col0, col1;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  bit ready = 0;
  logic [DW-1:0] mem [DEPTH];
  exp_t exp_q [4][$];
  int   col_q [2][$];

  param_dual_port_ram #(.RDW_MODE(RDW_OLD)) u_dut_old (
    .clk(clk), .rst_n(rst_n),
    .a_addr(ra.addr), .a_read_en(ra.rd), .a_write_en(ra.wr), .a_byte_en(ra.be), .a_data_in(ra.d),
    .a_data_out(ado0), .a_data_valid(av0),
    .b_addr(rb.addr), .b_read_en(rb.rd), .b_write_en(rb.wr), .b_byte_en(rb.be), .b_data_in(rb.d),
    .b_data_out(bdo0), .b_data_valid(bv0),
    .init_busy(busy0), .collision(col0)
  );

  param_dual_port_ram #(.RDW_MODE(RDW_NEW)) u_dut_new (
    .clk(clk), .rst_n(rst_n),
    .a_addr(ra.addr), .a_read_en(ra.rd), .a_write_en(ra.wr), .a_byte_en(ra.be), .a_data_in(ra.d),
    .a_data_out(ado1), .a_data_valid(av1),
    .b_addr(rb.addr), .b_read_en(rb.rd), .b_write_en(rb.wr), .b_byte_en(rb.be), .b_data_in(rb.d),
    .b_data_out(bdo1), .b_data_valid(bv1),
    .init_busy(busy1), .collision(col1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] lane_mask(input int l);
    logic [DW-1:0] m;
    m = {{(DW-BW){1'b0}}, {BW{1'b1}}};
    return m << (l * BW);
  endfunction

  function automatic req_t mk(input logic rd, input logic wr, input int addr, input int be, input int d);
    req_t r;
    r.rd = rd; r.wr = wr; r.addr = AW'(addr); r.be = LN'(be); r.d = DW'(d);
    return r;
  endfunction

  function automatic req_t rnd_req(input int amax);
    return mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, amax),
              $urandom_range(0, 3), $urandom_range(0, (1 << DW) - 1));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge: apply requests, update the model, advance one cycle.
  task automatic drive(input req_t a, input req_t b);
    logic [DW-1:0] nm [DEPTH];
    exp_t e;
    ra = a;
    rb = b;
    if (ready) begin
      nm = mem;
      for (int l = 0; l < LN; l++) begin
        logic [DW-1:0] lm;
        lm = lane_mask(l);
        if (a.wr && a.be[l])
          nm[a.addr] = (nm[a.addr] & ~lm) | (a.d & lm);
        if (b.wr && b.be[l] && !(a.wr && a.be[l] && a.addr == b.addr))
          nm[b.addr] = (nm[b.addr] & ~lm) | (b.d & lm);
      end
      e.c = cyc + LAT;
      if (a.rd) begin
        e.d = mem[a.addr]; exp_q[0].push_back(e);
        e.d = nm[a.addr];  exp_q[2].push_back(e);
      end
      if (b.rd) begin
        e.d = mem[b.addr]; exp_q[1].push_back(e);
        e.d = nm[b.addr];  exp_q[3].push_back(e);
      end
      if (a.wr && b.wr && a.addr == b.addr && (a.be & b.be) != '0) begin
        col_q[0].push_back(cyc + LAT);
        col_q[1].push_back(cyc + LAT);
      end
      mem = nm;
    end
    @(negedge clk);
  endtask

  task automatic mon_port(input int p, input logic v, input logic [DW-1:0] d);
    exp_t e;
    if (v) begin
      n_cmp++;
      if (exp_q[p].size() == 0) begin
        n_bad++;
        $display("FAIL port%0d_read: got unexpected valid data=%0h at cycle %0d, expected no valid", p, d, cyc);
      end else begin
        e = exp_q[p].pop_front();
        if (d !== e.d || cyc != e.c) begin
          n_bad++;
          $display("FAIL port%0d_read: got %0h at cycle %0d, expected %0h at cycle %0d", p, d, cyc, e.d, e.c);
        end
      end
    end else if (exp_q[p].size() != 0 && exp_q[p][0].c <= cyc) begin
      e = exp_q[p].pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL port%0d_read: got no valid at cycle %0d, expected %0h", p, cyc, e.d);
    end
  endtask

  task automatic mon_col(input int p, input logic c);
    int ec;
    if (c) begin
      n_cmp++;
      if (col_q[p].size() == 0) begin
        n_bad++;
        $display("FAIL collision%0d: got pulse at cycle %0d, expected none", p, cyc);
      end else begin
        ec = col_q[p].pop_front();
        if (ec != cyc) begin
          n_bad++;
          $display("FAIL collision%0d: got pulse at cycle %0d, expected cycle %0d", p, cyc, ec);
        end
      end
    end else if (col_q[p].size() != 0 && col_q[p][0] <= cyc) begin
      ec = col_q[p].pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL collision%0d: got no pulse at cycle %0d, expected pulse at %0d", p, cyc, ec);
    end
  endtask

  always @(posedge clk) begin
    #1;
    mon_port(0, av0, ado0);
    mon_port(1, bv0, bdo0);
    mon_port(2, av1, ado1);
    mon_port(3, bv1, bdo1);
    mon_col(0, col0);
    mon_col(1, col1);
  end

  task automatic chk_reset_outputs();
    chk("rst_a_out_old", 32'(ado0), 0);
    chk("rst_b_out_new", 32'(bdo1), 0);
    chk("rst_valid", {28'd0, av0, bv0, av1, bv1}, 0);
    chk("rst_collision", {30'd0, col0, col1}, 0);
    chk("rst_busy", {30'd0, busy0, busy1}, 32'd3);
  endtask

  // Entered at the negedge where rst_n has just been released.
  task automatic clear_phase();
    int k0, k1, n;
    k0 = 0; k1 = 0; n = 0;
    while ((busy0 || busy1) && n < 200) begin
      if (busy0) k0++;
      if (busy1) k1++;
      n++;
      drive(rnd_req(DEPTH - 1), rnd_req(DEPTH - 1));
    end
    chk("busy_len_old", 32'(k0), DEPTH);
    chk("busy_len_new", 32'(k1), DEPTH);
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    ready = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0));
  endtask

  initial begin
    ra = '0;
    rb = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;
    clear_phase();

    drive(mk(1, 0, 63, 0, 0), mk(0, 0, 0, 0, 0));
    drive(mk(0, 1, 5, 3, 'h1ABC), mk(0, 0, 0, 0, 0));
    drive(mk(0, 0, 0, 0, 0), mk(1, 0, 5, 0, 0));
    drive(mk(0, 1, 9, 3, 'h0011), mk(0, 0, 0, 0, 0));
    drive(mk(0, 1, 9, 3, 'h2222), mk(1, 0, 9, 0, 0));
    drive(mk(0, 1, 3, 2, 'h3FFF), mk(0, 0, 0, 0, 0));
    drive(mk(1, 0, 3, 0, 0), mk(0, 0, 0, 0, 0));
    drive(mk(1, 1, 7, 3, 'h1111), mk(0, 1, 7, 1, 'h2222));
    drive(mk(1, 0, 7, 0, 0), mk(0, 0, 0, 0, 0));
    drive(mk(0, 1, 7, 2, 'h1111), mk(1, 1, 7, 1, 'h2222));
    drive(mk(1, 0, 7, 0, 0), mk(1, 0, 7, 0, 0));
    drive(mk(0, 1, 12, 0, 'h3FFF), mk(1, 1, 12, 0, 'h1234));
    drive(mk(1, 0, 12, 0, 0), mk(0, 0, 0, 0, 0));
    idle(4);

    for (int i = 0; i < 400; i++) drive(rnd_req(7), rnd_req(7));
    for (int i = 0; i < 200; i++) drive(rnd_req(DEPTH - 1), rnd_req(DEPTH - 1));
    idle(4);

    ready = 0;
    rst_n = 1'b0;
    idle(1);
    chk_reset_outputs();
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) drive(rnd_req(DEPTH - 1), rnd_req(DEPTH - 1));
    rst_n = 1'b0;
    drive(rnd_req(DEPTH - 1), rnd_req(DEPTH - 1));
    rst_n = 1'b1;
    clear_phase();

    for (int i = 0; i < DEPTH; i++) drive(mk(1, 0, i, 0, 0), mk(1, 0, DEPTH - 1 - i, 0, 0));
    for (int i = 0; i < 400; i++) drive(rnd_req(5), rnd_req(5));
    idle(5);

    for (int p = 0; p < 4; p++) chk($sformatf("drain_port%0d", p), 32'(exp_q[p].size()), 0);
    for (int p = 0; p < 2; p++) chk($sformatf("drain_col%0d", p), 32'(col_q[p].size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
